execute_pipe: RTL and testbench
===============================

# execute_pipe

Parametrised, pipelined execute stage for the MIPS datapath, successor to the single-cycle execute stage. It accepts one decoded operation per valid/ready handshake, selects register or extended immediate for operand B, and computes the ALU result and the jump target PC. Results are held in a registered output slot with backpressure. A built-in iterative multiplier gives variable latency. It sits between the decoder and the memory/writeback stage.

## Interface
- DATA_W, 32, ALU operand/result width (≥8, power of two)
- IMM_W, 27, immediate and jump-offset width (< DATA_W, < PC_W)
- PC_W, 32, program counter width
- CLOCK_50  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  decoder presents an operation
- in_ready  output  1  stage accepts this cycle
- program_counter  input  PC_W  PC of the operation
- alu_A  input  DATA_W  operand A
- alu_B  input  DATA_W  register operand B
- immediate  input  IMM_W  immediate operand
- pc_increment_jump  input  IMM_W  signed PC offset
- alu_opcode  input  4  operation select
- select_immediate  input  1  1: B = extended immediate
- sign_extend_imm  input  1  1: sign-extend immediate; 0: zero-extend
- out_valid  output  1  result slot full
- out_ready  input  1  downstream consumes slot
- alu_out  output  DATA_W  result
- program_counter_jumped  output  PC_W  jump target
- zero_flag  output  1  alu_out == 0
- overflow_flag  output  1  signed overflow (ADD/SUB only, else 0)
- busy  output  1  multiplier in progress

## Operation
- Handshake: an operation is accepted at a rising edge where in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Slot drains at any edge with out_valid && out_ready. Outputs hold stable while out_valid && !out_ready.
- B = select_immediate ? ext(immediate) : alu_B. ext extends to DATA_W, signed or zero per sign_extend_imm sampled at acceptance.
- Jump target = program_counter + sign-extended pc_increment_jump, modulo 2^PC_W. It is computed for every op and registered with the result.
- Opcodes; all arithmetic is modulo 2^DATA_W; shift amount is B[log2(DATA_W)-1:0]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU: 1 or 0
  - 8 SLL, 9 SRL, 10 SRA
  - 11 PASSB, 12 MUL (low DATA_W bits of A*B, unsigned shift-add)
  - 13–15: result 0, flags 0
- FSM: IDLE → (accept opcode 12) → MUL → (DATA_W iterations done) → IDLE.
  - MUL processes one multiplier bit per cycle from captured copies of A, B and the target.
  - busy = (state == MUL).
- Flags are computed from the registered result in the same cycle as it is loaded.
- Reset (any time, including mid-MUL):
  - out_valid=0, alu_out=0, program_counter_jumped=0, zero_flag=0, overflow_flag=0, busy=0, state=IDLE.
  - An in-progress multiply is discarded and no output is produced.

## Timing
- Single-cycle ops: accepted at edge N, out_valid=1 after edge N. Throughput is one per cycle when out_ready is held high.
- MUL: accepted at edge N, iterations at edges N+1..N+DATA_W, out_valid=1 after edge N+DATA_W. in_ready=0 for cycles N+1..N+DATA_W.
- The slot is always free at MUL completion, because acceptance required it free or draining.
- Simultaneous drain and accept at one edge: the new result replaces the old with no bubble.
- in_ready is combinational from state, out_valid and out_ready only. It never depends on in_valid.
- Back-to-back MULs: the second is accepted no earlier than the cycle after the first result appears, provided out_ready=1.

## Test plan
- Reset mid-MUL: assert reset at cycle 5 of a MUL → all outputs 0 at once, busy=0. After release, in_ready=1 and no stale result appears.
- ADD with immediate, sign-extend: A=5, immediate=27'h7FFFFFF, select_immediate=1, sign_extend_imm=1 → alu_out=4, out_valid one cycle later. Same with sign_extend_imm=0 → alu_out=0x08000004.
- Overflow and zero: SUB A=0x80000000, B=1 → alu_out=0x7FFFFFFF, overflow_flag=1. SUB A=B=7 → alu_out=0, zero_flag=1.
- Jump target: program_counter=0x100, pc_increment_jump=-8 → program_counter_jumped=0xF8. With program_counter=0xFFFFFFFC and offset 8 → 0x4 (wrap).
- MUL latency and stall: A=0x10001, B=0x10003 → alu_out=0x00040003 exactly 32 cycles after acceptance. in_ready=0 and busy=1 throughout. Then hold out_ready=0 for 3 cycles → outputs stable and in_ready=0.
- Backpressure streaming: 4 ADDs with out_ready toggling 1,0,1,1 → results in order, none dropped or duplicated, in_ready tracks the formula every cycle.

Source files
------------

// File: rtl/execute_pipe.sv
// execute_pipe
//   Pipelined execute stage. Accepts one decoded operation per valid/ready
//   handshake. Operand B is either the register value or the extended
//   immediate. The stage computes the ALU result and the jump target and
//   holds both in a registered output slot with backpressure. MUL runs on an
//   iterative shift-add multiplier, one multiplier bit per cycle.
//
// Handshake semantics (both sides):
//   A transfer happens at a rising edge where valid && ready. The producer
//   holds its payload stable while valid && !ready. in_ready is a function of
//   FSM state, out_valid and out_ready only, and never of in_valid. The
//   output slot holds alu_out, program_counter_jumped and the flags stable
//   while out_valid && !out_ready.
//
// Ports
//   CLOCK_50, reset          : clock (rising edge), async active-high reset
//   in_valid / in_ready      : upstream handshake
//   program_counter          : PC of the operation
//   alu_A, alu_B             : register operands
//   immediate                : immediate operand (IMM_W bits)
//   pc_increment_jump        : signed PC offset (IMM_W bits)
//   alu_opcode               : operation select
//   select_immediate         : 1 -> operand B is the extended immediate
//   sign_extend_imm          : 1 -> sign-extend the immediate, 0 -> zero-extend
//   out_valid / out_ready    : downstream handshake on the result slot
//   alu_out                  : result
//   program_counter_jumped   : jump target registered with the result
//   zero_flag, overflow_flag : flags of the registered result
//   busy                     : multiply in progress
//   debug_state              : current FSM state (0 IDLE, 1 MUL)
module execute_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 27,
  parameter int PC_W   = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   program_counter,
  input  logic [DATA_W-1:0] alu_A,
  input  logic [DATA_W-1:0] alu_B,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [IMM_W-1:0]  pc_increment_jump,
  input  logic [3:0]        alu_opcode,
  input  logic              select_immediate,
  input  logic              sign_extend_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic [PC_W-1:0]   program_counter_jumped,
  output logic              zero_flag,
  output logic              overflow_flag,
  output logic              busy,
  output logic              debug_state
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Combinational datapath for the operation being presented.
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] result;
  logic              result_ovf;
  logic              result_zero;
  logic [PC_W-1:0]   jump_target;

  // Iterative multiplier state.
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_acc_next;
  logic [CNT_W-1:0]  mul_cnt;
  logic [PC_W-1:0]   mul_pc;
  logic              mul_last;

  logic accept;
  logic accept_mul;
  logic load_single;
  logic load_mul;

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign busy        = (state_q == ST_MUL);
  assign debug_state = state_q;

  assign accept      = in_valid && in_ready;
  assign accept_mul  = accept && (alu_opcode == OP_MUL);
  assign load_single = accept && (alu_opcode != OP_MUL);
  assign mul_last    = (mul_cnt == CNT_W'(DATA_W - 1));
  assign load_mul    = (state_q == ST_MUL) && mul_last;

  assign jump_target = program_counter
                     + {{(PC_W - IMM_W){pc_increment_jump[IMM_W-1]}}, pc_increment_jump};

  always_comb begin
    imm_ext = sign_extend_imm
            ? {{(DATA_W - IMM_W){immediate[IMM_W-1]}}, immediate}
            : {{(DATA_W - IMM_W){1'b0}}, immediate};
    op_b  = select_immediate ? imm_ext : alu_B;
    sum   = alu_A + op_b;
    diff  = alu_A - op_b;
    shamt = op_b[SH_W-1:0];

    result     = '0;
    result_ovf = 1'b0;
    unique case (alu_opcode)
      OP_ADD: begin
        result     = sum;
        // Same-sign operands producing a result of the other sign.
        result_ovf = (alu_A[DATA_W-1] == op_b[DATA_W-1])
                  && (sum[DATA_W-1] != alu_A[DATA_W-1]);
      end
      OP_SUB: begin
        result     = diff;
        result_ovf = (alu_A[DATA_W-1] != op_b[DATA_W-1])
                  && (diff[DATA_W-1] != alu_A[DATA_W-1]);
      end
      OP_AND:   result = alu_A & op_b;
      OP_OR:    result = alu_A | op_b;
      OP_XOR:   result = alu_A ^ op_b;
      OP_NOR:   result = ~(alu_A | op_b);
      OP_SLT:   result = DATA_W'($signed(alu_A) < $signed(op_b));
      OP_SLTU:  result = DATA_W'(alu_A < op_b);
      OP_SLL:   result = alu_A << shamt;
      OP_SRL:   result = alu_A >> shamt;
      OP_SRA:   result = DATA_W'($signed(alu_A) >>> shamt);
      OP_PASSB: result = op_b;
      default:  result = '0;  // MUL handled by the multiplier; 13-15 yield 0
    endcase

    // Reserved opcodes report no flags even though their result is zero.
    result_zero = (alu_opcode <= OP_PASSB) && (result == '0);
  end

  assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Multiplier: multiplicand shifts left, multiplier shifts right, one bit per cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
      mul_pc  <= '0;
    end else if (accept_mul) begin
      mul_a   <= alu_A;
      mul_b   <= op_b;
      mul_acc <= '0;
      mul_cnt <= '0;
      mul_pc  <= jump_target;
    end else if (state_q == ST_MUL) begin
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_acc <= mul_acc_next;
      mul_cnt <= mul_cnt + CNT_W'(1);
    end
  end

  // Output slot. A load while the old result drains replaces it with no bubble.
  // The slot is always free or draining when a multiply completes, because
  // the multiply was only accepted with in_ready high and nothing else can
  // load the slot while the FSM is in MUL.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_valid              <= 1'b0;
      alu_out                <= '0;
      program_counter_jumped <= '0;
      zero_flag              <= 1'b0;
      overflow_flag          <= 1'b0;
    end else if (load_single) begin
      out_valid              <= 1'b1;
      alu_out                <= result;
      program_counter_jumped <= jump_target;
      zero_flag              <= result_zero;
      overflow_flag          <= result_ovf;
    end else if (load_mul) begin
      out_valid              <= 1'b1;
      alu_out                <= mul_acc_next;
      program_counter_jumped <= mul_pc;
      zero_flag              <= (mul_acc_next == '0);
      overflow_flag          <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
module tb_execute_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] program_counter;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [26:0] immediate;
  logic [26:0] pc_increment_jump;
  logic [3:0]  alu_opcode;
  logic        select_immediate;
  logic        sign_extend_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic [31:0] program_counter_jumped;
  logic        zero_flag;
  logic        overflow_flag;
  logic        busy;
  logic        debug_state;

  int checks = 0;
  int errors = 0;

  execute_pipe #(.DATA_W(32), .IMM_W(27), .PC_W(32)) dut (
    .CLOCK_50               (clk),
    .reset                  (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .program_counter        (program_counter),
    .alu_A                  (alu_A),
    .alu_B                  (alu_B),
    .immediate              (immediate),
    .pc_increment_jump      (pc_increment_jump),
    .alu_opcode             (alu_opcode),
    .select_immediate       (select_immediate),
    .sign_extend_imm        (sign_extend_imm),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .alu_out                (alu_out),
    .program_counter_jumped (program_counter_jumped),
    .zero_flag              (zero_flag),
    .overflow_flag          (overflow_flag),
    .busy                   (busy),
    .debug_state            (debug_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one op at posedge+1, hold it over one edge, then drop valid.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [26:0] imm, input logic sel, input logic sx,
                      input logic [31:0] pc, input logic [26:0] off);
    alu_opcode        = op;
    alu_A             = a;
    alu_B             = b;
    immediate         = imm;
    select_immediate  = sel;
    sign_extend_imm   = sx;
    program_counter   = pc;
    pc_increment_jump = off;
    in_valid          = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    alu_opcode = '0; alu_A = '0; alu_B = '0; immediate = '0;
    select_immediate = 1'b0; sign_extend_imm = 1'b0;
    program_counter = '0; pc_increment_jump = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_out !== 32'h0 || program_counter_jumped !== 32'h0) begin
      errors++;
      $display("FAIL reset_slot: out_valid=%0b alu_out=%h pcj=%h, want 0 0 0",
               out_valid, alu_out, program_counter_jumped);
    end
    checks++;
    if (zero_flag !== 1'b0 || overflow_flag !== 1'b0 || busy !== 1'b0 || debug_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: z=%0b v=%0b busy=%0b st=%0b, want all 0",
               zero_flag, overflow_flag, busy, debug_state);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_add_imm();
    out_ready = 1'b1;
    send(4'd0, 32'd5, 32'h0, 27'h7FFFFFF, 1'b1, 1'b1, 32'h0, 27'h0);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'd4 || overflow_flag !== 1'b0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL add_imm_sext: valid=%0b out=%h v=%0b z=%0b, want 1 00000004 0 0",
               out_valid, alu_out, overflow_flag, zero_flag);
    end
    send(4'd0, 32'd5, 32'h0, 27'h7FFFFFF, 1'b1, 1'b0, 32'h0, 27'h0);
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'h08000004) begin
      errors++;
      $display("FAIL add_imm_zext: valid=%0b out=%h, want 1 08000004", out_valid, alu_out);
    end
  endtask

  task automatic test_sub_flags();
    out_ready = 1'b1;
    send(4'd1, 32'h80000000, 32'd1, 27'h0, 1'b0, 1'b0, 32'h0, 27'h0);
    checks++;
    if (alu_out !== 32'h7FFFFFFF || overflow_flag !== 1'b1 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL sub_overflow: out=%h v=%0b z=%0b, want 7fffffff 1 0",
               alu_out, overflow_flag, zero_flag);
    end
    send(4'd1, 32'd7, 32'd7, 27'h0, 1'b0, 1'b0, 32'h0, 27'h0);
    checks++;
    if (alu_out !== 32'h0 || zero_flag !== 1'b1 || overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: out=%h z=%0b v=%0b, want 0 1 0", alu_out, zero_flag, overflow_flag);
    end
  endtask

  task automatic test_jump();
    out_ready = 1'b1;
    send(4'd0, 32'd1, 32'd1, 27'h0, 1'b0, 1'b0, 32'h00000100, 27'h7FFFFF8);
    checks++;
    if (program_counter_jumped !== 32'h000000F8) begin
      errors++;
      $display("FAIL jump_back: got %h want 000000f8", program_counter_jumped);
    end
    send(4'd0, 32'd1, 32'd1, 27'h0, 1'b0, 1'b0, 32'hFFFFFFFC, 27'd8);
    checks++;
    if (program_counter_jumped !== 32'h00000004) begin
      errors++;
      $display("FAIL jump_wrap: got %h want 00000004", program_counter_jumped);
    end
  endtask

  // Opcode sweep with A=800000F0, B=00000F04 (shift amount 4).
  task automatic test_logic();
    logic [31:0] exp_tbl [0:12];
    logic        expz_tbl [0:12];
    logic [3:0]  op_tbl [0:12];
    exp_tbl[0]  = 32'h80000FF4; op_tbl[0]  = 4'd0;   // ADD
    exp_tbl[1]  = 32'h00000000; op_tbl[1]  = 4'd2;   // AND
    exp_tbl[2]  = 32'h80000FF4; op_tbl[2]  = 4'd3;   // OR
    exp_tbl[3]  = 32'h80000FF4; op_tbl[3]  = 4'd4;   // XOR
    exp_tbl[4]  = 32'h7FFFF00B; op_tbl[4]  = 4'd5;   // NOR
    exp_tbl[5]  = 32'h00000001; op_tbl[5]  = 4'd6;   // SLT
    exp_tbl[6]  = 32'h00000000; op_tbl[6]  = 4'd7;   // SLTU
    exp_tbl[7]  = 32'h00000F00; op_tbl[7]  = 4'd8;   // SLL
    exp_tbl[8]  = 32'h0800000F; op_tbl[8]  = 4'd9;   // SRL
    exp_tbl[9]  = 32'hF800000F; op_tbl[9]  = 4'd10;  // SRA
    exp_tbl[10] = 32'h00000F04; op_tbl[10] = 4'd11;  // PASSB
    exp_tbl[11] = 32'h00000000; op_tbl[11] = 4'd13;  // reserved
    exp_tbl[12] = 32'h00000000; op_tbl[12] = 4'd15;  // reserved
    for (int i = 0; i < 13; i++) expz_tbl[i] = 1'b0;
    expz_tbl[1] = 1'b1;
    expz_tbl[6] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(op_tbl[i], 32'h800000F0, 32'h00000F04, 27'h0, 1'b0, 1'b0, 32'h0, 27'h0);
      checks++;
      if (out_valid !== 1'b1 || alu_out !== exp_tbl[i] || zero_flag !== expz_tbl[i]
          || overflow_flag !== 1'b0) begin
        errors++;
        $display("FAIL logic_op%0d: valid=%0b out=%h z=%0b v=%0b, want 1 %h %0b 0",
                 op_tbl[i], out_valid, alu_out, zero_flag, overflow_flag, exp_tbl[i], expz_tbl[i]);
      end
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
    send(4'd12, 32'h00010001, 32'h00010003, 27'h0, 1'b0, 1'b0, 32'h00000200, 27'd16);
    // Edges N+0 .. N+31: multiply in flight.
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_stall_c%0d: busy=%0b in_ready=%0b out_valid=%0b, want 1 0 0",
                 k, busy, in_ready, out_valid);
      end
      if (k < 31) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'h00040003 || busy !== 1'b0
        || program_counter_jumped !== 32'h00000210 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: valid=%0b out=%h busy=%0b pcj=%h z=%0b, want 1 00040003 0 00000210 0",
               out_valid, alu_out, busy, program_counter_jumped, zero_flag);
    end
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || alu_out !== 32'h00040003 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mul_hold_c%0d: valid=%0b out=%h in_ready=%0b, want 1 00040003 0",
                 k, out_valid, alu_out, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_drain: out_valid=%0b want 0", out_valid);
    end
  endtask

  // Four ADDs streamed under out_ready pattern 1,0,1,1 with a scoreboard.
  task automatic test_back_to_back();
    logic [31:0] a_tbl [0:3];
    logic [31:0] b_tbl [0:3];
    logic [31:0] e_tbl [0:3];
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [3:0]  pat;
    int idx;
    int c;
    a_tbl[0] = 32'h00000001; b_tbl[0] = 32'h00000002; e_tbl[0] = 32'h00000003;
    a_tbl[1] = 32'h00000010; b_tbl[1] = 32'h00000020; e_tbl[1] = 32'h00000030;
    a_tbl[2] = 32'hFFFFFFFF; b_tbl[2] = 32'h00000001; e_tbl[2] = 32'h00000000;
    a_tbl[3] = 32'h12345678; b_tbl[3] = 32'h11111111; e_tbl[3] = 32'h23456789;
    pat = 4'b1101;
    idx = 0;
    c = 0;
    alu_opcode = 4'd0; select_immediate = 1'b0; sign_extend_imm = 1'b0;
    while ((idx < 4 || exp_q.size() > 0) && c < 30) begin
      out_ready = pat[c % 4];
      in_valid  = (idx < 4);
      if (idx < 4) begin
        alu_A = a_tbl[idx];
        alu_B = b_tbl[idx];
      end
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL stream_in_ready_c%0d: got %0b with out_valid=%0b out_ready=%0b",
                 c, in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra_c%0d: unexpected result %h", c, alu_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (alu_out !== exp_v) begin
            errors++;
            $display("FAIL stream_data_c%0d: got %h want %h", c, alu_out, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(e_tbl[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (c >= 30) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d, %0d results pending", idx, exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_dup: out_valid=%0b after last drain, want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    out_ready = 1'b1;
    send(4'd0, 32'h00001234, 32'h00000001, 27'h0, 1'b0, 1'b0, 32'h00000040, 27'd4);
    send(4'd12, 32'd5, 32'd3, 27'h0, 1'b0, 1'b0, 32'h0, 27'h0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmm_busy_before: got %0b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_out !== 32'h0 || program_counter_jumped !== 32'h0
        || zero_flag !== 1'b0 || overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL rmm_async: busy=%0b valid=%0b out=%h pcj=%h z=%0b v=%0b, want all 0",
               busy, out_valid, alu_out, program_counter_jumped, zero_flag, overflow_flag);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmm_in_ready: got %0b want 1", in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmm_stale: out_valid or busy rose after reset (out_valid=%0b busy=%0b), want 0",
               out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_sub_flags();
    test_jump();
    test_logic();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
